// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
package mouse_pkg;

    localparam int BYTE_WIDTH  = 8;
    localparam int DELTA_WIDTH = 9;
    localparam int WHEEL_WIDTH = 4;

    // Bit positions inside packet byte 0
    localparam int B0_LEFT   = 0;
    localparam int B0_RIGHT  = 1;
    localparam int B0_MIDDLE = 2;
    localparam int B0_SYNC   = 3;
    localparam int B0_XSIGN  = 4;
    localparam int B0_YSIGN  = 5;
    localparam int B0_XOVF   = 6;
    localparam int B0_YOVF   = 7;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        WAIT_B3 = 2'd3
    } mouse_rx_state_t;

    // Byte-0 fields kept after the sync bit has been checked
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic middle;
        logic right;
        logic left;
    } mouse_b0_t;

    // Join a sign bit from byte 0 with the magnitude byte into a 9-bit two's-complement delta
    function automatic logic [DELTA_WIDTH-1:0] make_delta(input logic sign,
                                                          input logic [BYTE_WIDTH-1:0] mag);
        return {sign, mag};
    endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Combinational next-position for one cursor axis: adds or subtracts a signed
// delta, saturates to [0, max], or holds the position when the axis overflowed.
module mouse_axis_clamp
    import mouse_pkg::*;
#(
    parameter int POS_WIDTH = 11
) (
    input  logic [POS_WIDTH-1:0]          pos_i,
    input  logic signed [DELTA_WIDTH-1:0] delta_i,
    input  logic [POS_WIDTH-1:0]          max_i,
    input  logic                          sub_i,
    input  logic                          hold_i,
    output logic [POS_WIDTH-1:0]          pos_o
);

    // Two guard bits: one for the carry past max, one for the sign
    localparam int W = POS_WIDTH + 2;

    logic signed [W-1:0] pos_ext;
    logic signed [W-1:0] delta_ext;
    logic signed [W-1:0] max_ext;
    logic signed [W-1:0] sum;

    assign pos_ext   = {2'b00, pos_i};
    assign delta_ext = {{(W-DELTA_WIDTH){delta_i[DELTA_WIDTH-1]}}, delta_i};
    assign max_ext   = {2'b00, max_i};

    // Add/subtract at the widened size, then saturate into the legal range
    always_comb begin
        sum   = sub_i ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
        pos_o = pos_i;
        if (!hold_i) begin
            if (sum[W-1]) begin
                pos_o = '0;
            end else if (sum > max_ext) begin
                pos_o = max_i;
            end else begin
                pos_o = sum[POS_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse packet decoder: frames 3- or 4-byte packets, checks the byte-0
// sync bit, drops partial packets after an inter-byte timeout, and keeps a
// clamped cursor position.
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int PACKET_BYTES   = 3,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int POS_WIDTH      = 11,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BYTE_WIDTH-1:0]  i_byte,
    input  logic                   i_byte_valid,
    output logic                   o_valid,
    output logic                   o_left,
    output logic                   o_right,
    output logic                   o_middle,
    output logic [DELTA_WIDTH-1:0] o_dx,
    output logic [DELTA_WIDTH-1:0] o_dy,
    output logic [WHEEL_WIDTH-1:0] o_dz,
    output logic                   o_x_ovf,
    output logic                   o_y_ovf,
    output logic [POS_WIDTH-1:0]   o_x_pos,
    output logic [POS_WIDTH-1:0]   o_y_pos,
    output logic                   o_sync_err,
    output logic                   o_timeout
);

    localparam int                   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [POS_WIDTH-1:0] X_HOME   = POS_WIDTH'(X_MAX >> 1);
    localparam logic [POS_WIDTH-1:0] Y_HOME   = POS_WIDTH'(Y_MAX >> 1);

    if (PACKET_BYTES != 3 && PACKET_BYTES != 4) begin : g_bad_param
        $error("mouse_packet_decoder: PACKET_BYTES must be 3 or 4");
    end

    mouse_rx_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic timeout_hit;
    logic b0_cap;
    logic x_cap;
    logic pkt_done;
    logic sync_err_d;
    logic timeout_d;

    mouse_b0_t             b0_q;
    logic [BYTE_WIDTH-1:0] bx_q;
    logic [BYTE_WIDTH-1:0] y_byte;
    logic [WHEEL_WIDTH-1:0] z_nib;
    logic [DELTA_WIDTH-1:0] dx_d, dy_d;

    logic                   valid_q, sync_err_q, timeout_q;
    logic [2:0]             btn_q;
    logic [1:0]             ovf_q;
    logic [DELTA_WIDTH-1:0] dx_q, dy_q;
    logic [WHEEL_WIDTH-1:0] dz_q;

    // Index 0 is X, index 1 is Y
    logic [POS_WIDTH-1:0]   pos_q      [2];
    logic [POS_WIDTH-1:0]   axis_next  [2];
    logic [POS_WIDTH-1:0]   axis_max   [2];
    logic [DELTA_WIDTH-1:0] axis_delta [2];
    logic                   axis_sub   [2];
    logic                   axis_hold  [2];

    // A byte in the threshold cycle takes priority over the timeout
    assign timeout_hit = (state_q != WAIT_B0) && !i_byte_valid && (cnt_q == CNT_LAST);

    // State and inter-byte counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_B0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance one slot per byte, fall back to WAIT_B0 on timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_B0: if (i_byte_valid && i_byte[B0_SYNC]) state_d = WAIT_B1;
            WAIT_B1: if (i_byte_valid) state_d = WAIT_B2;
            WAIT_B2: if (i_byte_valid) state_d = (PACKET_BYTES == 4) ? WAIT_B3 : WAIT_B0;
            WAIT_B3: if (i_byte_valid) state_d = WAIT_B0;
            default: state_d = WAIT_B0;
        endcase
        if (timeout_hit) begin
            state_d = WAIT_B0;
        end
        cnt_d = (i_byte_valid || state_d == WAIT_B0) ? '0 : cnt_q + CNT_W'(1);
    end

    // FSM outputs: capture enables, packet completion and error strobes
    always_comb begin
        b0_cap     = (state_q == WAIT_B0) && i_byte_valid && i_byte[B0_SYNC];
        sync_err_d = (state_q == WAIT_B0) && i_byte_valid && !i_byte[B0_SYNC];
        x_cap      = (state_q == WAIT_B1) && i_byte_valid;
        pkt_done   = i_byte_valid &&
                     (((state_q == WAIT_B2) && (PACKET_BYTES != 4)) || (state_q == WAIT_B3));
        timeout_d  = timeout_hit;
    end

    // The last byte of a packet feeds the outputs directly, so only the wheel
    // build needs to hold the Y byte until the Z byte arrives
    if (PACKET_BYTES == 4) begin : g_wheel
        logic [BYTE_WIDTH-1:0] by_q;

        // Hold Y while waiting for the wheel byte
        always_ff @(posedge clk) begin
            if (rst) begin
                by_q <= '0;
            end else if ((state_q == WAIT_B2) && i_byte_valid) begin
                by_q <= i_byte;
            end
        end

        assign y_byte = by_q;
        assign z_nib  = i_byte[WHEEL_WIDTH-1:0];
    end else begin : g_std
        assign y_byte = i_byte;
        assign z_nib  = '0;
    end

    assign dx_d = make_delta(b0_q.x_sign, bx_q);
    assign dy_d = make_delta(b0_q.y_sign, y_byte);

    // PS/2 +dy is up while screen Y grows downward, so Y subtracts
    assign axis_delta[0] = dx_d;
    assign axis_delta[1] = dy_d;
    assign axis_max[0]   = POS_WIDTH'(X_MAX);
    assign axis_max[1]   = POS_WIDTH'(Y_MAX);
    assign axis_sub[0]   = 1'b0;
    assign axis_sub[1]   = 1'b1;
    assign axis_hold[0]  = b0_q.x_ovf;
    assign axis_hold[1]  = b0_q.y_ovf;

    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        mouse_axis_clamp #(
            .POS_WIDTH (POS_WIDTH)
        ) u_clamp (
            .pos_i   (pos_q[gi]),
            .delta_i (axis_delta[gi]),
            .max_i   (axis_max[gi]),
            .sub_i   (axis_sub[gi]),
            .hold_i  (axis_hold[gi]),
            .pos_o   (axis_next[gi])
        );
    end

    // Byte capture, output registers and cursor position
    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q       <= '0;
            bx_q       <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            btn_q      <= '0;
            ovf_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            dz_q       <= '0;
            pos_q[0]   <= X_HOME;
            pos_q[1]   <= Y_HOME;
        end else begin
            valid_q    <= pkt_done;
            sync_err_q <= sync_err_d;
            timeout_q  <= timeout_d;
            if (b0_cap) begin
                b0_q <= '{y_ovf:  i_byte[B0_YOVF],
                          x_ovf:  i_byte[B0_XOVF],
                          y_sign: i_byte[B0_YSIGN],
                          x_sign: i_byte[B0_XSIGN],
                          middle: i_byte[B0_MIDDLE],
                          right:  i_byte[B0_RIGHT],
                          left:   i_byte[B0_LEFT]};
            end
            if (x_cap) begin
                bx_q <= i_byte;
            end
            if (pkt_done) begin
                btn_q    <= {b0_q.middle, b0_q.right, b0_q.left};
                ovf_q    <= {b0_q.y_ovf, b0_q.x_ovf};
                dx_q     <= dx_d;
                dy_q     <= dy_d;
                dz_q     <= z_nib;
                pos_q[0] <= axis_next[0];
                pos_q[1] <= axis_next[1];
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_left     = btn_q[0];
    assign o_right    = btn_q[1];
    assign o_middle   = btn_q[2];
    assign o_dx       = dx_q;
    assign o_dy       = dy_q;
    assign o_dz       = dz_q;
    assign o_x_ovf    = ovf_q[0];
    assign o_y_ovf    = ovf_q[1];
    assign o_x_pos    = pos_q[0];
    assign o_y_pos    = pos_q[1];
    assign o_sync_err = sync_err_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Bench for mouse_packet_decoder: a 3-byte and a 4-byte instance side by side,
// checked every cycle against a packet-level reference model, plus a table of
// known packets and a few hand-written timing sequences.
module tb_mouse_packet_decoder;

    localparam int T  = 20;
    localparam int XM = 639;
    localparam int YM = 479;
    localparam int PW = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] b_in [2];
    logic       v_in [2];

    logic          o_valid    [2];
    logic          o_left     [2];
    logic          o_right    [2];
    logic          o_middle   [2];
    logic [8:0]    o_dx       [2];
    logic [8:0]    o_dy       [2];
    logic [3:0]    o_dz       [2];
    logic          o_x_ovf    [2];
    logic          o_y_ovf    [2];
    logic [PW-1:0] o_x_pos    [2];
    logic [PW-1:0] o_y_pos    [2];
    logic          o_sync_err [2];
    logic          o_timeout  [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mouse_packet_decoder #(
        .PACKET_BYTES(3), .TIMEOUT_CYCLES(T), .POS_WIDTH(PW), .X_MAX(XM), .Y_MAX(YM)
    ) dut3 (
        .clk(clk), .rst(rst), .i_byte(b_in[0]), .i_byte_valid(v_in[0]),
        .o_valid(o_valid[0]), .o_left(o_left[0]), .o_right(o_right[0]), .o_middle(o_middle[0]),
        .o_dx(o_dx[0]), .o_dy(o_dy[0]), .o_dz(o_dz[0]),
        .o_x_ovf(o_x_ovf[0]), .o_y_ovf(o_y_ovf[0]),
        .o_x_pos(o_x_pos[0]), .o_y_pos(o_y_pos[0]),
        .o_sync_err(o_sync_err[0]), .o_timeout(o_timeout[0])
    );

    mouse_packet_decoder #(
        .PACKET_BYTES(4), .TIMEOUT_CYCLES(T), .POS_WIDTH(PW), .X_MAX(XM), .Y_MAX(YM)
    ) dut4 (
        .clk(clk), .rst(rst), .i_byte(b_in[1]), .i_byte_valid(v_in[1]),
        .o_valid(o_valid[1]), .o_left(o_left[1]), .o_right(o_right[1]), .o_middle(o_middle[1]),
        .o_dx(o_dx[1]), .o_dy(o_dy[1]), .o_dz(o_dz[1]),
        .o_x_ovf(o_x_ovf[1]), .o_y_ovf(o_y_ovf[1]),
        .o_x_pos(o_x_pos[1]), .o_y_pos(o_y_pos[1]),
        .o_sync_err(o_sync_err[1]), .o_timeout(o_timeout[1])
    );

    // ---------------- reference model (packet level) ----------------
    int         m_len [2];
    int         m_gap [2];
    logic [7:0] m_buf [2][4];
    int         m_x   [2];
    int         m_y   [2];
    bit         e_valid [2], e_l [2], e_r [2], e_m [2], e_xo [2], e_yo [2], e_sync [2], e_to [2];
    int         e_dx [2], e_dy [2], e_dz [2];

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int sext(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    task automatic model_decode(input int d);
        logic [7:0] p0;
        logic [7:0] pz;
        p0 = m_buf[d][0];
        pz = m_buf[d][3];
        e_valid[d] = 1'b1;
        e_l[d]  = p0[0];
        e_r[d]  = p0[1];
        e_m[d]  = p0[2];
        e_xo[d] = p0[6];
        e_yo[d] = p0[7];
        e_dx[d] = sext(int'(m_buf[d][1]) + (p0[4] ? 256 : 0), 9);
        e_dy[d] = sext(int'(m_buf[d][2]) + (p0[5] ? 256 : 0), 9);
        e_dz[d] = (d == 1) ? sext(int'(pz) % 16, 4) : 0;
        if (!p0[6]) m_x[d] = clampi(m_x[d] + e_dx[d], XM);
        if (!p0[7]) m_y[d] = clampi(m_y[d] - e_dy[d], YM);
        m_len[d] = 0;
    endtask

    task automatic model_step(input int d, input bit r, input bit v, input logic [7:0] b);
        int nb;
        nb = (d == 1) ? 4 : 3;
        e_valid[d] = 1'b0;
        e_sync[d]  = 1'b0;
        e_to[d]    = 1'b0;
        if (r) begin
            m_len[d] = 0;  m_gap[d] = 0;
            e_l[d] = 0; e_r[d] = 0; e_m[d] = 0; e_xo[d] = 0; e_yo[d] = 0;
            e_dx[d] = 0; e_dy[d] = 0; e_dz[d] = 0;
            m_x[d] = XM / 2;  m_y[d] = YM / 2;
        end else if (v) begin
            m_gap[d] = 0;
            if (m_len[d] == 0 && !b[3]) begin
                e_sync[d] = 1'b1;
            end else begin
                m_buf[d][m_len[d]] = b;
                m_len[d]++;
                if (m_len[d] == nb) model_decode(d);
            end
        end else if (m_len[d] > 0) begin
            m_gap[d]++;
            if (m_gap[d] == T) begin
                m_len[d] = 0;
                e_to[d]  = 1'b1;
            end
        end
    endtask

    // ---------------- checking ----------------
    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic compare(input int d);
        string s;
        s = (d == 0) ? "d3" : "d4";
        chk({s, ".valid"},    int'(o_valid[d]),         int'(e_valid[d]));
        chk({s, ".left"},     int'(o_left[d]),          int'(e_l[d]));
        chk({s, ".right"},    int'(o_right[d]),         int'(e_r[d]));
        chk({s, ".middle"},   int'(o_middle[d]),        int'(e_m[d]));
        chk({s, ".dx"},       int'($signed(o_dx[d])),   e_dx[d]);
        chk({s, ".dy"},       int'($signed(o_dy[d])),   e_dy[d]);
        chk({s, ".dz"},       int'($signed(o_dz[d])),   e_dz[d]);
        chk({s, ".x_ovf"},    int'(o_x_ovf[d]),         int'(e_xo[d]));
        chk({s, ".y_ovf"},    int'(o_y_ovf[d]),         int'(e_yo[d]));
        chk({s, ".x_pos"},    int'(o_x_pos[d]),         m_x[d]);
        chk({s, ".y_pos"},    int'(o_y_pos[d]),         m_y[d]);
        chk({s, ".sync_err"}, int'(o_sync_err[d]),      int'(e_sync[d]));
        chk({s, ".timeout"},  int'(o_timeout[d]),       int'(e_to[d]));
    endtask

    // One clock: inputs were set at the previous negedge, outputs checked at this negedge
    task automatic tick();
        @(posedge clk);
        model_step(0, rst, v_in[0], b_in[0]);
        model_step(1, rst, v_in[1], b_in[1]);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic send(input int d, input logic [7:0] b);
        v_in[0] = (d == 0);
        v_in[1] = (d == 1);
        b_in[0] = b;
        b_in[1] = b;
        tick();
        v_in[0] = 1'b0;
        v_in[1] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if ($urandom_range(0, 5) != 0) b[3] = 1'b1;
        return b;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        int rs, d;
        int b0, b1, b2, b3;
        int l, r, m;
        int dx, dy, dz;
        int xo, yo;
        int x, y;
    } vec_t;

    vec_t tbl [22];

    initial begin
        //          rs d  b0    b1    b2    b3     l r m  dx    dy   dz  xo yo  x    y
        tbl[0]  = '{1, 0, 'h29, 'h05, 'hFB, 0,     1,0,0, 5,    -5,  0,  0,0, 324, 244};
        tbl[1]  = '{1, 1, 'h0C, 0,    0,    'h0F,  0,0,1, 0,    0,   -1, 0,0, 319, 239};
        tbl[2]  = '{0, 0, 'h48, 'h10, 0,    0,     0,0,0, 16,   0,   0,  1,0, 319, 239};
        tbl[3]  = '{1, 0, 'h19, 'h05, 'hFB, 0,     1,0,0, -251, 251, 0,  0,0, 68,  0};
        tbl[4]  = '{1, 0, 'h08, 'h7F, 0,    0,     0,0,0, 127,  0,   0,  0,0, 446, 239};
        tbl[5]  = '{0, 0, 'h08, 'h7F, 0,    0,     0,0,0, 127,  0,   0,  0,0, 573, 239};
        tbl[6]  = '{0, 0, 'h08, 'h7F, 0,    0,     0,0,0, 127,  0,   0,  0,0, 639, 239};
        tbl[7]  = '{0, 0, 'h08, 'h7F, 0,    0,     0,0,0, 127,  0,   0,  0,0, 639, 239};
        tbl[8]  = '{0, 0, 'h08, 'h7F, 0,    0,     0,0,0, 127,  0,   0,  0,0, 639, 239};
        tbl[9]  = '{0, 0, 'h08, 'h7F, 0,    0,     0,0,0, 127,  0,   0,  0,0, 639, 239};
        tbl[10] = '{0, 0, 'h08, 0,    'h7F, 0,     0,0,0, 0,    127, 0,  0,0, 639, 112};
        tbl[11] = '{0, 0, 'h08, 0,    'h0C, 0,     0,0,0, 0,    12,  0,  0,0, 639, 100};
        tbl[12] = '{0, 0, 'h08, 0,    'h7F, 0,     0,0,0, 0,    127, 0,  0,0, 639, 0};
        tbl[13] = '{0, 0, 'h28, 0,    'h80, 0,     0,0,0, 0,    -128,0,  0,0, 639, 128};
        tbl[14] = '{0, 0, 'h28, 0,    'h80, 0,     0,0,0, 0,    -128,0,  0,0, 639, 256};
        tbl[15] = '{0, 0, 'h28, 0,    'h80, 0,     0,0,0, 0,    -128,0,  0,0, 639, 384};
        tbl[16] = '{0, 0, 'h28, 0,    'h80, 0,     0,0,0, 0,    -128,0,  0,0, 639, 479};
        tbl[17] = '{0, 0, 'h18, 'h80, 0,    0,     0,0,0, -128, 0,   0,  0,0, 511, 479};
        tbl[18] = '{0, 0, 'h0A, 0,    0,    0,     0,1,0, 0,    0,   0,  0,0, 511, 479};
        tbl[19] = '{0, 0, 'hCB, 'h7F, 'h7F, 0,     1,1,0, 127,  127, 0,  1,1, 511, 479};
        tbl[20] = '{1, 1, 'h09, 'h03, 'h02, 'h05,  1,0,0, 3,    2,   5,  0,0, 322, 237};
        tbl[21] = '{0, 1, 'h08, 0,    0,    'hF7,  0,0,0, 0,    0,   7,  0,0, 322, 237};
    end

    // ---------------- stimulus ----------------
    initial begin
        int p;
        v_in[0] = 1'b0;  v_in[1] = 1'b0;
        b_in[0] = '0;    b_in[1] = '0;
        rst = 1'b1;
        tick();            // reset state checked by the scoreboard here
        rst = 1'b0;
        tick();

        // Table of known packets, bytes sent back-to-back
        for (int i = 0; i < 22; i++) begin
            int d;
            d = tbl[i].d;
            if (tbl[i].rs != 0) do_reset();
            send(d, 8'(tbl[i].b0));
            send(d, 8'(tbl[i].b1));
            send(d, 8'(tbl[i].b2));
            if (d == 1) send(d, 8'(tbl[i].b3));
            chk("tbl.valid",  int'(o_valid[d]),        1);
            chk("tbl.left",   int'(o_left[d]),         tbl[i].l);
            chk("tbl.right",  int'(o_right[d]),        tbl[i].r);
            chk("tbl.middle", int'(o_middle[d]),       tbl[i].m);
            chk("tbl.dx",     int'($signed(o_dx[d])),  tbl[i].dx);
            chk("tbl.dy",     int'($signed(o_dy[d])),  tbl[i].dy);
            chk("tbl.dz",     int'($signed(o_dz[d])),  tbl[i].dz);
            chk("tbl.x_ovf",  int'(o_x_ovf[d]),        tbl[i].xo);
            chk("tbl.y_ovf",  int'(o_y_ovf[d]),        tbl[i].yo);
            chk("tbl.x_pos",  int'(o_x_pos[d]),        tbl[i].x);
            chk("tbl.y_pos",  int'(o_y_pos[d]),        tbl[i].y);
            $display("vec %0d dut%0d bytes %02h %02h %02h %02h -> dx=%0d dy=%0d dz=%0d pos=(%0d,%0d)",
                     i, (d == 0) ? 3 : 4, tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3,
                     $signed(o_dx[d]), $signed(o_dy[d]), $signed(o_dz[d]), o_x_pos[d], o_y_pos[d]);
        end

        // Rejected byte 0, then a good packet
        do_reset();
        send(0, 8'h01);
        chk("sync.pulse", int'(o_sync_err[0]), 1);
        send(0, 8'h29);
        chk("sync.clear", int'(o_sync_err[0]), 0);
        send(0, 8'h05);
        send(0, 8'hFB);
        chk("sync.valid", int'(o_valid[0]), 1);
        chk("sync.x", int'(o_x_pos[0]), 324);
        chk("sync.y", int'(o_y_pos[0]), 244);
        $display("seq sync: sync_err then packet -> pos=(%0d,%0d)", o_x_pos[0], o_y_pos[0]);

        // Gap of T cycles after byte 0 discards it
        send(0, 8'h08);
        idle(T - 1);
        chk("tmo.early", int'(o_timeout[0]), 0);
        idle(1);
        chk("tmo.pulse", int'(o_timeout[0]), 1);
        idle(1);
        chk("tmo.once", int'(o_timeout[0]), 0);
        send(0, 8'h09);
        send(0, 8'h01);
        send(0, 8'h01);
        chk("tmo.valid", int'(o_valid[0]), 1);
        chk("tmo.dx", int'($signed(o_dx[0])), 1);
        chk("tmo.x", int'(o_x_pos[0]), 325);
        chk("tmo.y", int'(o_y_pos[0]), 243);
        $display("seq timeout: fresh packet -> pos=(%0d,%0d)", o_x_pos[0], o_y_pos[0]);

        // Byte landing exactly on the threshold cycle is accepted
        send(0, 8'h08);
        idle(T - 1);
        send(0, 8'h02);
        chk("thr.no_tmo", int'(o_timeout[0]), 0);
        send(0, 8'h03);
        chk("thr.valid", int'(o_valid[0]), 1);
        chk("thr.dx", int'($signed(o_dx[0])), 2);
        chk("thr.dy", int'($signed(o_dy[0])), 3);
        chk("thr.x", int'(o_x_pos[0]), 327);
        chk("thr.y", int'(o_y_pos[0]), 240);
        $display("seq threshold: pos=(%0d,%0d)", o_x_pos[0], o_y_pos[0]);

        // Wheel build times out while waiting for the Z byte
        send(1, 8'h08);
        send(1, 8'h00);
        send(1, 8'h00);
        idle(T);
        chk("tmo4.pulse", int'(o_timeout[1]), 1);
        send(1, 8'h08);
        send(1, 8'h00);
        send(1, 8'h00);
        send(1, 8'h01);
        chk("tmo4.valid", int'(o_valid[1]), 1);
        chk("tmo4.dz", int'($signed(o_dz[1])), 1);
        $display("seq wheel timeout: dz=%0d", $signed(o_dz[1]));

        // Reset after two bytes: no strobe, next byte treated as byte 0
        send(0, 8'h09);
        send(0, 8'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst.valid", int'(o_valid[0]), 0);
        chk("rst.x", int'(o_x_pos[0]), XM / 2);
        chk("rst.y", int'(o_y_pos[0]), YM / 2);
        chk("rst.dx", int'(o_dx[0]), 0);
        send(0, 8'h10);
        chk("rst.novalid", int'(o_valid[0]), 0);
        chk("rst.sync", int'(o_sync_err[0]), 1);
        $display("seq reset mid-packet: pos=(%0d,%0d)", o_x_pos[0], o_y_pos[0]);

        // Random bytes, alternating dense bursts and sparse traffic
        p = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) p = (p == 60) ? 4 : 60;
            rst     = ($urandom_range(0, 799) == 0);
            v_in[0] = ($urandom_range(0, 99) < p);
            v_in[1] = ($urandom_range(0, 99) < p);
            b_in[0] = rand_byte();
            b_in[1] = rand_byte();
            tick();
        end
        rst = 1'b0;
        v_in[0] = 1'b0;
        v_in[1] = 1'b0;
        idle(2);
        $display("random phase done: pos3=(%0d,%0d) pos4=(%0d,%0d)",
                 o_x_pos[0], o_y_pos[0], o_x_pos[1], o_y_pos[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
